power_down_sequence: RTL
========================

Name: power_down_sequence

Overview:
- Reverse of the board power-up sequencer: on a shutdown request it re-asserts the two downstream resets in reverse release order, waits programmable millisecond delays, then acknowledges.
- Sits between the power-up sequencer outputs and the downstream reset consumers.
- Passes the power-up resets through unchanged when idle.
- Reset polarity of all reset_* signals: 0 = held in reset, 1 = released.

Parameters:
- C_CLK_FREQ, 100_000, clk frequency in kHz; cycles per ms.
- R1_TO_R2_DELAY, 5, ms between forcing reset_1 low and forcing reset_2 low.
- OFF_DELAY, 10, ms that both resets are held low before pd_done.

Ports:
- clk  input  1  system clock (100 MHz nominal).
- reset  input  1  asynchronous, active-high block reset.
- reset_1_in  input  1  reset_1 from power-up sequencer.
- reset_2_in  input  1  reset_2 from power-up sequencer.
- pd_req  input  1  power-down request, level, synchronous to clk.
- reset_1  output  1  gated reset_1 to downstream (registered).
- reset_2  output  1  gated reset_2 to downstream (registered).
- pd_done  output  1  power-down complete acknowledge (registered).
- pd_busy  output  1  high while in R1_OFF or R2_OFF (registered).

Behaviour:
- One clock, clk. reset is asynchronous and active-high: reset high forces state IDLE, counter 0, reset_1=0, reset_2=0, pd_done=0, pd_busy=0.
- Cycle counts:
  - R1_CYCLES = max(1, R1_TO_R2_DELAY*C_CLK_FREQ).
  - OFF_CYCLES = max(1, OFF_DELAY*C_CLK_FREQ).
  - Counter width: clog2(max(R1_CYCLES, OFF_CYCLES))+1 bits, unsigned, never wraps.
- States: IDLE, R1_OFF, R2_OFF, DONE. The state register updates on the clk edge.
- Outputs are registered from the current state (one cycle after state change):
  - reset_1 = reset_1_in AND (state==IDLE).
  - reset_2 = reset_2_in AND (state==IDLE or state==R1_OFF).
  - pd_done = (state==DONE).
  - pd_busy = (state==R1_OFF or state==R2_OFF).
- IDLE: counter held at 0. At the edge pd_req==1 is sampled, go to R1_OFF.
- R1_OFF:
  - Counter increments each cycle.
  - At the edge with counter==R1_CYCLES-1, go to R2_OFF and clear the counter.
  - R1_OFF therefore lasts exactly R1_CYCLES cycles.
- R2_OFF:
  - Same counting against OFF_CYCLES-1, then go to DONE and clear the counter.
  - Lasts exactly OFF_CYCLES cycles.
- DONE:
  - Hold while pd_req==1.
  - At the edge pd_req==0 is sampled, go to IDLE. Outputs return to pass-through one cycle later.
- Once the sequence has started, pd_req deassertion during R1_OFF/R2_OFF is ignored and the sequence always completes.
- Inputs low during the sequence: the outputs remain low (the AND gating).
- Asserting reset mid-sequence aborts immediately to the reset values above.
- reset_1_in/reset_2_in toggling in IDLE appear on the outputs with 1-cycle latency.

Test Plan:
- Pass-through: C_CLK_FREQ=1, R1_TO_R2_DELAY=5, OFF_DELAY=10, pd_req=0. Drive reset_1_in/reset_2_in with 0,1,1,0 patterns -> outputs equal the inputs delayed 1 cycle; pd_done=0, pd_busy=0 throughout.
- Full sequence: same parameters, both inputs 1, pd_req set high and first sampled at edge k.
  - At edge k+1: reset_1=0, pd_busy=1.
  - At edge k+6: reset_2=0.
  - At edge k+16: pd_done=1, pd_busy=0.
  - pd_done stays 1 while pd_req=1.
- Release: from DONE, pd_req=0 sampled at edge m -> at edge m+1 pd_done=0, reset_1=1, reset_2=1.
- Early request drop: pd_req pulsed high for 1 cycle only -> the full sequence still runs with the same timing as above. pd_done=1 lasts exactly 1 cycle, then the block returns to IDLE.
- Reset mid-operation: assert reset asynchronously 3 cycles into R2_OFF -> all outputs 0 immediately without waiting for a clk edge. After reset deasserts with pd_req=0 and inputs=1, the outputs return to 1 after the first clk edge.
- Zero-delay corner: R1_TO_R2_DELAY=0 and OFF_DELAY=0 -> R1_OFF and R2_OFF each last 1 cycle. pd_done asserts at edge k+3 after the request is sampled at k.

Source files
------------

// File: rtl/power_down_sequence.sv
// power_down_sequence: on pd_req, forces reset_1 then reset_2 low with ms delays, then acks with pd_done.
module power_down_sequence #(
  parameter int C_CLK_FREQ     = 100_000,
  parameter int R1_TO_R2_DELAY = 5,
  parameter int OFF_DELAY      = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic reset_1_in,
  input  logic reset_2_in,
  input  logic pd_req,
  output logic reset_1,
  output logic reset_2,
  output logic pd_done,
  output logic pd_busy
);
  localparam int R1_CYCLES  = (R1_TO_R2_DELAY * C_CLK_FREQ > 1) ? R1_TO_R2_DELAY * C_CLK_FREQ : 1;
  localparam int OFF_CYCLES = (OFF_DELAY * C_CLK_FREQ > 1) ? OFF_DELAY * C_CLK_FREQ : 1;
  localparam int CW         = $clog2(R1_CYCLES > OFF_CYCLES ? R1_CYCLES : OFF_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, R1_OFF, R2_OFF, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  // outputs decode the pre-edge state, so they lag the state by one cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      reset_1 <= 1'b0;
      reset_2 <= 1'b0;
      pd_done <= 1'b0;
      pd_busy <= 1'b0;
    end else begin
      reset_1 <= reset_1_in && state == IDLE;
      reset_2 <= reset_2_in && (state == IDLE || state == R1_OFF);
      pd_done <= state == DONE;
      pd_busy <= state == R1_OFF || state == R2_OFF;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pd_req) state <= R1_OFF;
        end
        R1_OFF:
          if (cnt == CW'(R1_CYCLES - 1)) begin
            state <= R2_OFF;
            cnt   <= '0;
          end else cnt <= cnt + CW'(1);
        R2_OFF:
          if (cnt == CW'(OFF_CYCLES - 1)) begin
            state <= DONE;
            cnt   <= '0;
          end else cnt <= cnt + CW'(1);
        default: if (!pd_req) state <= IDLE;
      endcase
    end
endmodule
